// File: rtl/fire8_expand1_ofm_writer_if.sv
// Sample-in / RAM-write-out bundle for the fire8_expand1 output-feature-map writer.
// The master modport drives samples; the slave modport is the writer itself.
interface fire8_expand1_ofm_writer_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 256,
    parameter int WOUT   = 8,
    parameter int LANES  = 4,
    parameter int AW     = $clog2((DSP_NO / LANES) * WOUT * WOUT)
);
    logic                     ofm_sample_i;
    logic [WIDTH-1:0]         ofm_i [0:DSP_NO-1];
    logic                     wr_en_o;
    logic [AW-1:0]            wr_addr_o;
    logic [LANES*WIDTH-1:0]   wr_data_o;
    logic                     busy_o;
    logic                     overrun_o;
    logic                     ram_feedback_o;

    modport master (
        output ofm_sample_i, ofm_i,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, overrun_o, ram_feedback_o
    );

    modport slave (
        input  ofm_sample_i, ofm_i,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, overrun_o, ram_feedback_o
    );
endinterface

// File: rtl/fire8_expand1_ofm_writer.sv
// Captures each 256-word OFM sample and drains it LANES words per cycle into the
// output RAM at address beat*PIX + pixel; pulses ram_feedback after the last pixel.
module fire8_expand1_ofm_writer #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 256,
    parameter int WOUT   = 8,
    parameter int LANES  = 4,
    parameter int AW     = $clog2((DSP_NO / LANES) * WOUT * WOUT)
) (
    input  logic clk,
    input  logic rst,
    fire8_expand1_ofm_writer_if.slave bus
);
    localparam int BEATS = DSP_NO / LANES;
    localparam int PIX   = WOUT * WOUT;
    localparam int BW    = $clog2(BEATS);
    localparam int PW    = $clog2(PIX);
    localparam int IW    = $clog2(DSP_NO);
    localparam int DW    = LANES * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_FINISHED = 2'd2
    } state_t;

    state_t           r_state;
    logic [BW-1:0]    r_beat;
    logic [PW-1:0]    r_pix;
    logic [WIDTH-1:0] r_shadow [0:DSP_NO-1];
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [DW-1:0]    r_wr_data;
    logic             r_busy;
    logic             r_overrun;
    logic             r_feedback;

    logic [BW-1:0]    w_nxt_beat;
    logic [PW-1:0]    w_nxt_pix;
    logic [DW-1:0]    w_cap_data;
    logic [DW-1:0]    w_shd_data;
    logic             w_last_beat;
    logic             w_last_pix;
    logic             w_capture;

    function automatic logic [AW-1:0] beat_addr(input logic [BW-1:0] b, input logic [PW-1:0] p);
        return AW'(b) * AW'(PIX) + AW'(p);
    endfunction

    assign w_nxt_beat  = r_beat + BW'(1);
    assign w_nxt_pix   = r_pix + PW'(1);
    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_last_pix  = (r_pix == PW'(PIX - 1));
    assign w_capture   = bus.ofm_sample_i &&
                         ((r_state == S_IDLE) ||
                          ((r_state == S_DRAIN) && w_last_beat && !w_last_pix));

    // The first beat of a fresh sample bypasses the shadow; later beats read it.
    always_comb begin
        w_cap_data = '0;
        w_shd_data = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cap_data[k*WIDTH +: WIDTH] = bus.ofm_i[k];
            w_shd_data[k*WIDTH +: WIDTH] = r_shadow[IW'(w_nxt_beat) * IW'(LANES) + IW'(k)];
        end
    end

    // Shadow buffer: loaded only on an accepted sample, never reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_shadow <= bus.ofm_i;
        end
    end

    // Control FSM with registered write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_pix      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_feedback <= 1'b0;
        end else begin
            r_feedback <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ofm_sample_i) begin
                        r_state   <= S_DRAIN;
                        r_beat    <= '0;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_addr <= beat_addr('0, r_pix);
                        r_wr_data <= w_cap_data;
                    end else begin
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!w_last_beat) begin
                        r_beat    <= w_nxt_beat;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_addr <= beat_addr(w_nxt_beat, r_pix);
                        r_wr_data <= w_shd_data;
                        if (bus.ofm_sample_i) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (w_last_pix) begin
                        r_state    <= S_FINISHED;
                        r_wr_en    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_feedback <= 1'b1;
                        if (bus.ofm_sample_i) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (bus.ofm_sample_i) begin
                        r_pix     <= w_nxt_pix;
                        r_beat    <= '0;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_addr <= beat_addr('0, w_nxt_pix);
                        r_wr_data <= w_cap_data;
                    end else begin
                        r_pix   <= w_nxt_pix;
                        r_state <= S_IDLE;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_FINISHED: begin
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    if (bus.ofm_sample_i) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en_o        = r_wr_en;
    assign bus.wr_addr_o      = r_wr_addr;
    assign bus.wr_data_o      = r_wr_data;
    assign bus.busy_o         = r_busy;
    assign bus.overrun_o      = r_overrun;
    assign bus.ram_feedback_o = r_feedback;
endmodule

// File: tb/tb_fire8_expand1_ofm_writer.sv
// Self-checking bench: a cycle-indexed model of expected RAM writes, feedback and
// overrun is compared against the writer every cycle, plus pinned literal values.
module tb_fire8_expand1_ofm_writer;
    localparam int WIDTH  = 16;
    localparam int DSP_NO = 256;
    localparam int WOUT   = 8;
    localparam int LANES  = 4;
    localparam int BEATS  = DSP_NO / LANES;
    localparam int PIX    = WOUT * WOUT;
    localparam int DW     = LANES * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fire8_expand1_ofm_writer_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT), .LANES(LANES)) bus ();

    fire8_expand1_ofm_writer #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Model: expected write per cycle, plus feedback cycle and overrun start cycle.
    int            exp_addr [int];
    logic [DW-1:0] exp_data [int];
    int            m_pix;
    int            m_free_at;
    int            m_fb_cyc;
    int            m_ovr_from;
    bit            m_last_taken;
    logic [WIDTH-1:0] vec [DSP_NO];
    bit            checking = 1'b0;

    logic [DW-1:0] ram [BEATS*PIX];
    int            nwr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        exp_addr.delete();
        exp_data.delete();
        m_pix        = 0;
        m_free_at    = -1;
        m_fb_cyc     = -1;
        m_ovr_from   = -1;
        m_last_taken = 1'b0;
    endtask

    task automatic model_sample(input int t);
        logic [DW-1:0] d;
        if (m_last_taken || t < m_free_at) begin
            if (m_ovr_from < 0) m_ovr_from = t + 1;
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = vec[b*LANES + k];
                exp_addr[t + 1 + b] = b * PIX + m_pix;
                exp_data[t + 1 + b] = d;
            end
            m_free_at = t + BEATS;
            if (m_pix == PIX - 1) begin
                m_last_taken = 1'b1;
                m_fb_cyc     = t + BEATS + 1;
            end
            m_pix++;
        end
    endtask

    task automatic pulse();
        for (int i = 0; i < DSP_NO; i++) bus.ofm_i[i] = vec[i];
        bus.ofm_sample_i = 1'b1;
        model_sample(cyc);
        @(posedge clk); #1;
        bus.ofm_sample_i = 1'b0;
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < DSP_NO; i++) vec[i] = WIDTH'($urandom);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"},   64'(bus.wr_en_o),        64'd0);
        chk({nm, "_addr"}, 64'(bus.wr_addr_o),      64'd0);
        chk({nm, "_data"}, 64'(bus.wr_data_o),      64'd0);
        chk({nm, "_busy"}, 64'(bus.busy_o),         64'd0);
        chk({nm, "_ovr"},  64'(bus.overrun_o),      64'd0);
        chk({nm, "_fb"},   64'(bus.ram_feedback_o), 64'd0);
    endtask

    // Per-cycle comparison against the model.
    bit cmp_en;
    always @(negedge clk) begin
        if (checking) begin
            cmp_en = exp_addr.exists(cyc);
            chk("wr_en", 64'(bus.wr_en_o), 64'(cmp_en));
            chk("busy",  64'(bus.busy_o),  64'(cmp_en));
            if (cmp_en) begin
                chk("wr_addr", 64'(bus.wr_addr_o), 64'(exp_addr[cyc]));
                chk("wr_data", 64'(bus.wr_data_o), 64'(exp_data[cyc]));
            end
            chk("feedback", 64'(bus.ram_feedback_o), 64'(cyc == m_fb_cyc));
            chk("overrun",  64'(bus.overrun_o), 64'((m_ovr_from >= 0) && (cyc >= m_ovr_from)));
        end
    end

    // RAM image built from the write port.
    always @(negedge clk) begin
        if (bus.wr_en_o === 1'b1) begin
            ram[bus.wr_addr_o] = bus.wr_data_o;
            nwr++;
        end
    end

    initial begin
        int t;
        int tl;
        logic [DW-1:0] pv;
        bus.ofm_sample_i = 1'b0;
        for (int i = 0; i < DSP_NO; i++) bus.ofm_i[i] = '0;
        model_reset();
        @(posedge clk); #1;
        checking = 1'b1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single pixel, ramp data.
        t = cyc + 3;
        go(t);
        for (int i = 0; i < DSP_NO; i++) vec[i] = WIDTH'(i);
        pulse();
        chk("sp_addr0", 64'(bus.wr_addr_o), 64'd0);
        chk("sp_data0", 64'(bus.wr_data_o), 64'h0003_0002_0001_0000);
        go(t + 64);
        chk("sp_addr63", 64'(bus.wr_addr_o), 64'd4032);
        chk("sp_data63", 64'(bus.wr_data_o), 64'h00ff_00fe_00fd_00fc);
        go(t + 66);
        chk("sp_done_en", 64'(bus.wr_en_o), 64'd0);

        // Back-to-back on the last beat.
        do_reset();
        t = cyc + 2;
        go(t);
        rand_vec(); pulse();
        go(t + 64);
        rand_vec(); pulse();
        chk("b2b_addr", 64'(bus.wr_addr_o), 64'd1);
        go(t + 128);
        chk("b2b_addr_last", 64'(bus.wr_addr_o), 64'd4033);
        go(t + 130);
        chk("b2b_ovr", 64'(bus.overrun_o), 64'd0);

        // Overrun: second sample mid-drain is dropped.
        do_reset();
        t = cyc + 2;
        go(t);
        rand_vec(); pulse();
        go(t + 10);
        rand_vec(); pulse();
        chk("ovr_rise", 64'(bus.overrun_o), 64'd1);
        go(t + 80);
        rand_vec(); pulse();
        chk("ovr_next_pix", 64'(bus.wr_addr_o), 64'd1);
        go(t + 150);
        chk("ovr_sticky", 64'(bus.overrun_o), 64'd1);

        // Reset at beat 20 of the second pixel.
        do_reset();
        t = cyc + 2;
        go(t);
        rand_vec(); pulse();
        go(t + 64);
        rand_vec(); pulse();
        go(t + 85);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t = cyc + 2;
        go(t);
        rand_vec(); pulse();
        chk("midrst_restart", 64'(bus.wr_addr_o), 64'd0);
        go(t + 70);

        // Full layer, pixel value p in every channel.
        do_reset();
        nwr = 0;
        t = cyc + 2;
        for (int p = 0; p < PIX; p++) begin
            go(t + 113 * p);
            for (int i = 0; i < DSP_NO; i++) vec[i] = WIDTH'(p);
            pulse();
        end
        tl = t + 113 * (PIX - 1);
        go(tl + 65);
        chk("full_fb", 64'(bus.ram_feedback_o), 64'd1);
        chk("full_fb_busy", 64'(bus.busy_o), 64'd0);
        rand_vec(); pulse();
        chk("late_ovr", 64'(bus.overrun_o), 64'd1);
        chk("late_en", 64'(bus.wr_en_o), 64'd0);
        go(tl + 100);
        rand_vec(); pulse();
        go(tl + 120);
        chk("full_nwr", 64'(nwr), 64'd4096);
        for (int b = 0; b < BEATS; b++) begin
            for (int p = 0; p < PIX; p++) begin
                for (int k = 0; k < LANES; k++) pv[k*WIDTH +: WIDTH] = WIDTH'(p);
                chk("full_ram", 64'(ram[b*PIX + p]), 64'(pv));
            end
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
